// File: rtl/cpu_pattern_history_table.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pattern_history_table
// Description : Gshare branch-direction predictor for the fetch stage.
//               A table of 2^HIST_WIDTH 2-bit saturating counters is indexed
//               by the fetch PC XOR a speculative global history register
//               (GHR). The prediction qualifies a branch target buffer hit.
//               Execute-stage updates train the counters and, on a
//               mispredict, repair the GHR from the returned snapshot.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk               in  : clock, rising edge
//   rst               in  : synchronous, active-high reset
//   predict_addr      in  : fetch PC (bits [1:0] ignored)
//   predict_valid     in  : prediction consumed this cycle, GHR advances
//   predict_taken     out : predicted direction (combinational)
//   predict_ghr       out : GHR snapshot used for this prediction
//   update            in  : resolved conditional branch presented
//   update_addr       in  : PC of the resolved branch
//   update_ghr        in  : snapshot returned when that branch was predicted
//   update_taken      in  : actual outcome
//   update_mispredict in  : direction was mispredicted (qualified by update)
// ============================================================================
module cpu_pattern_history_table #(
  parameter int XLEN       = 32,
  parameter int HIST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       predict_addr,
  input  logic                  predict_valid,
  output logic                  predict_taken,
  output logic [HIST_WIDTH-1:0] predict_ghr,
  input  logic                  update,
  input  logic [XLEN-1:0]       update_addr,
  input  logic [HIST_WIDTH-1:0] update_ghr,
  input  logic                  update_taken,
  input  logic                  update_mispredict
);

  localparam int         ENTRIES   = 1 << HIST_WIDTH;
  localparam logic [1:0] C_CTR_RST = 2'b01;  // weakly not-taken
  localparam logic [1:0] C_CTR_MAX = 2'b11;
  localparam logic [1:0] C_CTR_MIN = 2'b00;

  logic [1:0]            r_ctr [ENTRIES];
  logic [HIST_WIDTH-1:0] r_ghr;

  logic [HIST_WIDTH-1:0] w_pred_idx;
  logic [HIST_WIDTH-1:0] w_upd_idx;
  logic [1:0]            w_upd_ctr;
  logic [1:0]            w_upd_ctr_next;

  // Only the word-index bits of each PC take part in the hash; the rest are
  // collected here so the intentionally ignored bits are visible in one place.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{predict_addr[XLEN-1:HIST_WIDTH+2], predict_addr[1:0],
                                update_addr[XLEN-1:HIST_WIDTH+2], update_addr[1:0]};

  assign w_pred_idx = predict_addr[HIST_WIDTH+1:2] ^ r_ghr;
  assign w_upd_idx  = update_addr[HIST_WIDTH+1:2] ^ update_ghr;

  // Read side sees the registered table, so a same-cycle update to the same
  // entry is only visible from the next cycle.
  assign predict_taken = r_ctr[w_pred_idx][1];
  assign predict_ghr   = r_ghr;

  assign w_upd_ctr = r_ctr[w_upd_idx];

  always_comb begin
    w_upd_ctr_next = w_upd_ctr;
    if (update_taken) begin
      if (w_upd_ctr != C_CTR_MAX) w_upd_ctr_next = w_upd_ctr + 2'd1;
    end else begin
      if (w_upd_ctr != C_CTR_MIN) w_upd_ctr_next = w_upd_ctr - 2'd1;
    end
  end

  // Counter table
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= C_CTR_RST;
      end
    end else if (update) begin
      r_ctr[w_upd_idx] <= w_upd_ctr_next;
    end
  end

  // Global history: a mispredict repair overrides the speculative shift of a
  // prediction made in the same cycle, since that prediction is on the
  // wrong path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (update && update_mispredict) begin
      r_ghr <= {update_ghr[HIST_WIDTH-2:0], update_taken};
    end else if (predict_valid) begin
      r_ghr <= {r_ghr[HIST_WIDTH-2:0], predict_taken};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_pattern_history_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_pattern_history_table
// Description : Scoreboard testbench for cpu_pattern_history_table. The
//               driver applies one cycle of inputs per step and queues the
//               hand-computed expected outputs for that cycle; a monitor pops
//               the queue and compares when a step is marked for checking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_pattern_history_table;

  localparam int XLEN = 32;
  localparam int HW   = 8;

  typedef struct {
    logic          taken;
    logic [HW-1:0] ghr;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] predict_addr;
  logic            predict_valid;
  logic            predict_taken;
  logic [HW-1:0]   predict_ghr;
  logic            update;
  logic [XLEN-1:0] update_addr;
  logic [HW-1:0]   update_ghr;
  logic            update_taken;
  logic            update_mispredict;

  // staged inputs for the next step
  logic            s_rst, s_pv, s_upd, s_ut, s_um;
  logic [XLEN-1:0] s_paddr, s_uaddr;
  logic [HW-1:0]   s_ughr;

  exp_t  exp_q[$];
  string name_q[$];
  bit    chk_req = 1'b0;
  int    checks  = 0;
  int    errors  = 0;

  cpu_pattern_history_table #(.XLEN(XLEN), .HIST_WIDTH(HW)) dut (
    .clk              (clk),
    .rst              (rst),
    .predict_addr     (predict_addr),
    .predict_valid    (predict_valid),
    .predict_taken    (predict_taken),
    .predict_ghr      (predict_ghr),
    .update           (update),
    .update_addr      (update_addr),
    .update_ghr       (update_ghr),
    .update_taken     (update_taken),
    .update_mispredict(update_mispredict)
  );

  always #5 clk = ~clk;

  task automatic stage(input logic r, input logic pv, input logic [XLEN-1:0] paddr,
                       input logic upd, input logic [XLEN-1:0] uaddr,
                       input logic [HW-1:0] ughr, input logic ut, input logic um);
    s_rst = r; s_pv = pv; s_paddr = paddr;
    s_upd = upd; s_uaddr = uaddr; s_ughr = ughr; s_ut = ut; s_um = um;
  endtask

  // One clock cycle: apply staged inputs at the falling edge and, if
  // requested, queue what the outputs must show before the next rising edge.
  task automatic go(input bit chk, input string nm, input logic et, input logic [HW-1:0] eg);
    exp_t e;
    @(negedge clk);
    rst = s_rst; predict_valid = s_pv; predict_addr = s_paddr;
    update = s_upd; update_addr = s_uaddr; update_ghr = s_ughr;
    update_taken = s_ut; update_mispredict = s_um;
    chk_req = chk;
    if (chk) begin
      e.taken = et;
      e.ghr   = eg;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic idle(input logic [XLEN-1:0] paddr);
    stage(0, 0, paddr, 0, 32'h0, 8'h00, 0, 0);
  endtask

  // Monitor: samples mid-low-phase, well away from the rising edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    #3;
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: no expected entry queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (predict_taken !== e.taken) begin
          errors++;
          $display("FAIL %s taken: got %b expected %b", nm, predict_taken, e.taken);
        end
        checks++;
        if (predict_ghr !== e.ghr) begin
          errors++;
          $display("FAIL %s ghr: got %h expected %h", nm, predict_ghr, e.ghr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stage(1, 0, 32'h0, 0, 32'h0, 8'h00, 0, 0);
    rst = 1; predict_valid = 0; predict_addr = 0; update = 0; update_addr = 0;
    update_ghr = 0; update_taken = 0; update_mispredict = 0;

    // Reset
    go(0, "", 0, 8'h00);
    idle(32'h1000);
    go(1, "reset_state", 0, 8'h00);
    stage(1, 1, 32'h1000, 1, 32'h1000, 8'h00, 1, 1);
    go(1, "reset_hold_pred", 0, 8'h00);
    idle(32'h1000);
    go(1, "reset_blocks_update", 0, 8'h00);
    stage(0, 0, 32'h1000, 0, 32'h0, 8'h5A, 1, 1);
    go(1, "mispredict_no_update_pre", 0, 8'h00);
    idle(32'h1000);
    go(1, "mispredict_no_update", 0, 8'h00);

    // Training / collision at index 0x40 (addr 0x100, ghr 0)
    stage(0, 0, 32'h100, 1, 32'h100, 8'h00, 1, 0);
    go(1, "collision_pre", 0, 8'h00);            // 01 -> 10
    idle(32'h100);
    go(1, "collision_post", 1, 8'h00);
    stage(0, 0, 32'h100, 1, 32'h100, 8'h00, 1, 0);
    go(1, "train_taken_2", 1, 8'h00);            // 10 -> 11
    go(1, "train_taken_3", 1, 8'h00);            // 11 -> 11
    go(1, "train_taken_4", 1, 8'h00);            // 11 -> 11
    stage(0, 0, 32'h100, 1, 32'h100, 8'h00, 0, 0);
    go(1, "train_nt_1", 1, 8'h00);               // 11 -> 10
    idle(32'h100);
    go(1, "sat_hi_then_nt", 1, 8'h00);
    stage(0, 0, 32'h100, 1, 32'h100, 8'h00, 0, 0);
    go(1, "train_nt_2", 1, 8'h00);               // 10 -> 01
    go(1, "train_nt_3", 0, 8'h00);               // 01 -> 00
    go(1, "train_nt_4", 0, 8'h00);               // 00 -> 00
    stage(0, 0, 32'h100, 1, 32'h100, 8'h00, 1, 0);
    go(1, "train_up_from_min", 0, 8'h00);        // 00 -> 01
    idle(32'h100);
    go(1, "sat_lo_hold", 0, 8'h00);
    stage(0, 0, 32'h100, 1, 32'h100, 8'h00, 1, 0);
    go(1, "retrain_1", 0, 8'h00);                // 01 -> 10
    go(1, "retrain_2", 1, 8'h00);                // 10 -> 11

    // Speculative history
    stage(0, 1, 32'h100, 0, 32'h0, 8'h00, 0, 0);
    go(1, "spec_pre", 1, 8'h00);                 // ghr -> 01
    idle(32'h100);
    go(1, "spec_post", 0, 8'h01);                // index 0x41

    // Repair priority over same-cycle shift; trains index 0x5A
    stage(0, 1, 32'h100, 1, 32'h0, 8'h5A, 1, 1);
    go(1, "repair_pre", 0, 8'h01);
    idle(32'h100);
    go(1, "repair_post", 0, 8'hB5);
    stage(0, 1, 32'h100, 1, 32'h0, 8'h5A, 1, 0);
    go(1, "no_repair_pre", 0, 8'hB5);
    idle(32'h0C0);                               // 0x30 ^ 0x6A = 0x5A
    go(1, "no_repair_post", 1, 8'h6A);

    // Aliasing through history
    stage(0, 0, 32'h0, 1, 32'h0, 8'h20, 0, 1);
    go(1, "alias_setup", 0, 8'h6A);              // ghr -> 0x40
    idle(32'h0);
    go(1, "alias_hist", 1, 8'h40);
    stage(0, 0, 32'h0, 1, 32'h0, 8'h00, 0, 1);
    go(1, "alias_clear", 1, 8'h40);              // ghr -> 0x00
    idle(32'h0);
    go(1, "alias_no_hist", 0, 8'h00);
    idle(32'h103);
    go(1, "addr_low_bits", 1, 8'h00);

    idle(32'h0);
    go(0, "", 0, 8'h00);
    go(0, "", 0, 8'h00);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
